fp32_fixp_unpack: RTL and testbench
===================================

// Module: fp32_fixp_unpack
// PURPOSE
//  Upstream feeder of the fixed-point shift/accumulate stage. Takes a stream of IEEE-754 FP32
//  words with an 8-bit accumulator-slot select and produces {shift, mantissa} beats for the
//  left shifter. Sign and slot select travel as sidebands aligned with each output beat.
//  Out-of-window, Inf and NaN inputs are flushed to zero and counted in saturating counters.
// PARAMETERS
//  PRE_REG_WIDTH  128  width of downstream pre-register; max shift = PRE_REG_WIDTH-24 (=104)
//  EXP_LO         87   biased exponent mapped to shift 0 (LSB of window)
//  CNT_W          16   width of each saturating status counter
// PORTS
//  clk             in   1   single clock
//  rstn            in   1   asynchronous, active-low reset
//  in_stream       slave stream, tdata 32: FP32 word; tvalid/tready
//  in_acc_cs       in   8   slot select, qualified by in_stream handshake
//  out_stream      master stream, tdata 31: {shift[6:0], mant[23:0]}; tvalid/tready
//  out_acc_cs      out  8   slot select, valid while out_stream.tvalid
//  out_sign        out  1   sign bit, valid while out_stream.tvalid
//  cnt_clr         in   1   synchronous clear of all counters (1-cycle pulse)
//  underflow_cnt   out  CNT_W  inputs with exponent below window (non-zero values only)
//  overflow_cnt    out  CNT_W  inputs with exponent above window
//  nan_inf_cnt     out  CNT_W  inputs with exponent 255
// BEHAVIOUR
//  - Reset: all valids 0, out_* data/sideband 0, counters 0, in_stream.tready 1.
//  - 2-stage pipeline (S1 decode, S2 output reg). Latency in->out = 2 cycles when not stalled.
//    Full throughput of 1 beat/cycle under continuous out_stream.tready=1.
//  - Stage advance rule: Sk loads when Sk empty or Sk's downstream handshake completes in the
//    same cycle. in_stream.tready = ~S1.valid | S1-advance (combinational from out ready
//    through S2). No beat is dropped or duplicated under any backpressure pattern.
//  - out_stream.tdata, out_acc_cs and out_sign stay stable while tvalid=1 and tready=0.
//  - Decode of e = word[30:23] and f = word[22:0]:
//    e=0, f=0: mant=0, shift=0, not counted (true zero).
//    e=0, f!=0: denormal. Implicit bit 0, effective exponent 1.
//    1<=e<=254: mant={1,f}.
//    e=255: mant=0, shift=0, nan_inf_cnt++.
//    s = eff_exp - EXP_LO (signed 9-bit).
//    s<0: mant=0, shift=0, underflow_cnt++.
//    s>PRE_REG_WIDTH-24: mant=0, shift=0, overflow_cnt++.
//    Otherwise shift=s[6:0].
//  - Sign is passed through unmodified for all cases, including flushed ones.
//  - Counters update at S1 load and saturate at all-ones.
//    cnt_clr wins over a same-cycle increment; the result is 0.
//  - Reset asserted mid-stream: in-flight beats are discarded; outputs return to reset values
//    asynchronously.
// STRUCTURE
//  - Shared package fixp_acc_pkg holds: FP32_MANT_W=24, SHIFT_W=7, ACC_CS_W=8, the
//    unpack_beat_t struct {shift, mant, sign, acc_cs}, and a flag enum {NORMAL, ZERO, UNDER,
//    OVER, NANINF}.
//  - One sub-module, fixp_sat_counter (CNT_W, inc, clr), is instantiated 3 times.
//  - Pipeline registers hold unpack_beat_t.
// TESTING
//  1. 1.0f (0x3F800000), cs=5, e=127: out tdata={7'd40, 24'h800000}, sign=0, cs=5, 2 cycles.
//  2. -2^-40 (e=87): shift=0, mant=0x800000, sign=1. Input 2^-41 (e=86): mant=0,
//     underflow_cnt=1.
//  3. 2^64 (e=191): shift=104 passes. 2^65 (e=192): mant=0, overflow_cnt=1.
//     0x7FC00000 (NaN): nan_inf_cnt=1.
//  4. Burst of 64 random words with out tready toggled randomly (50%): output sequence equals
//     the scoreboard model in order; no loss/dup; data held stable during stalls.
//  5. Preload underflow_cnt to 0xFFFF via repeated inputs: stays 0xFFFF.
//     cnt_clr on the same cycle as an increment -> 0.
//  6. Assert rstn low while 2 beats are in flight: tvalid=0 immediately.
//     After release, the first new input appears 2 cycles later with no stale beat.

Source files
------------

// File: rtl/fixp_acc_pkg.sv
// Shared types for the fixed-point accumulate path: beat layout between the FP32 unpacker
// and the left shifter, plus the decode classification used to steer the status counters.
package fixp_acc_pkg;

  localparam int FP32_MANT_W = 24;
  localparam int SHIFT_W     = 7;
  localparam int ACC_CS_W    = 8;

  typedef struct packed {
    logic [SHIFT_W-1:0]     shift;
    logic [FP32_MANT_W-1:0] mant;
    logic                   sign;
    logic [ACC_CS_W-1:0]    acc_cs;
  } unpack_beat_t;

  typedef enum logic [2:0] {
    NORMAL,
    ZERO,
    UNDER,
    OVER,
    NANINF
  } unpack_flag_t;

endpackage

// File: rtl/fixp_sat_counter.sv
// Saturating event counter with a synchronous clear that takes priority over increment.
module fixp_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fp32_fixp_unpack.sv
// FP32 -> {shift, mantissa} unpacker feeding the fixed-point shifter. Two-stage elastic
// pipeline (decode, output register); out-of-window and Inf/NaN words are flushed and counted.
module fp32_fixp_unpack
  import fixp_acc_pkg::*;
#(
  parameter int PRE_REG_WIDTH = 128,
  parameter int EXP_LO        = 87,
  parameter int CNT_W         = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [31:0]         in_stream_tdata,
  input  logic                in_stream_tvalid,
  output logic                in_stream_tready,
  input  logic [ACC_CS_W-1:0] in_acc_cs,
  output logic [30:0]         out_stream_tdata,
  output logic                out_stream_tvalid,
  input  logic                out_stream_tready,
  output logic [ACC_CS_W-1:0] out_acc_cs,
  output logic                out_sign,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    underflow_cnt,
  output logic [CNT_W-1:0]    overflow_cnt,
  output logic [CNT_W-1:0]    nan_inf_cnt
);

  localparam logic signed [8:0] EXP_LO_S    = 9'(EXP_LO);
  localparam logic signed [8:0] MAX_SHIFT_S = 9'(PRE_REG_WIDTH - FP32_MANT_W);

  logic [7:0]         exp_raw;
  logic [22:0]        frac;
  logic [7:0]         eff_exp;
  logic signed [8:0]  shift_s;
  unpack_flag_t       dec_flag;
  unpack_beat_t       dec_beat;

  logic               s1_valid_q, s1_valid_d;
  logic               s2_valid_q, s2_valid_d;
  unpack_beat_t       s1_beat_q, s1_beat_d;
  unpack_beat_t       s2_beat_q, s2_beat_d;
  logic               s2_ready;
  logic               in_fire;

  // Denormals use effective exponent 1 with a zero implicit bit.
  always_comb begin
    exp_raw         = in_stream_tdata[30:23];
    frac            = in_stream_tdata[22:0];
    eff_exp         = (exp_raw == 8'd0) ? 8'd1 : exp_raw;
    shift_s         = signed'({1'b0, eff_exp}) - EXP_LO_S;
    dec_flag        = NORMAL;
    dec_beat.shift  = '0;
    dec_beat.mant   = '0;
    dec_beat.sign   = in_stream_tdata[31];
    dec_beat.acc_cs = in_acc_cs;
    if (exp_raw == 8'hFF) begin
      dec_flag = NANINF;
    end else if ((exp_raw == 8'd0) && (frac == 23'd0)) begin
      dec_flag = ZERO;
    end else if (shift_s < 9'sd0) begin
      dec_flag = UNDER;
    end else if (shift_s > MAX_SHIFT_S) begin
      dec_flag = OVER;
    end else begin
      dec_beat.shift = shift_s[SHIFT_W-1:0];
      dec_beat.mant  = {(exp_raw != 8'd0), frac};
    end
  end

  // Ready ripples combinationally from the output port back to the input port.
  assign s2_ready         = ~s2_valid_q | out_stream_tready;
  assign in_stream_tready = ~s1_valid_q | s2_ready;
  assign in_fire          = in_stream_tvalid & in_stream_tready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_beat_d  = s1_beat_q;
    s2_valid_d = s2_valid_q;
    s2_beat_d  = s2_beat_q;
    if (in_stream_tready) begin
      s1_valid_d = in_stream_tvalid;
      if (in_stream_tvalid) s1_beat_d = dec_beat;
    end
    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_beat_d = s1_beat_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_beat_q  <= '0;
      s2_beat_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_beat_q  <= s1_beat_d;
      s2_beat_q  <= s2_beat_d;
    end
  end

  assign out_stream_tvalid = s2_valid_q;
  assign out_stream_tdata  = {s2_beat_q.shift, s2_beat_q.mant};
  assign out_acc_cs        = s2_beat_q.acc_cs;
  assign out_sign          = s2_beat_q.sign;

  fixp_sat_counter #(.CNT_W(CNT_W)) u_underflow_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (in_fire && (dec_flag == UNDER)),
    .clr  (cnt_clr),
    .cnt  (underflow_cnt)
  );

  fixp_sat_counter #(.CNT_W(CNT_W)) u_overflow_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (in_fire && (dec_flag == OVER)),
    .clr  (cnt_clr),
    .cnt  (overflow_cnt)
  );

  fixp_sat_counter #(.CNT_W(CNT_W)) u_nan_inf_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (in_fire && (dec_flag == NANINF)),
    .clr  (cnt_clr),
    .cnt  (nan_inf_cnt)
  );

endmodule

// File: tb/tb_fp32_fixp_unpack.sv
// Bench for fp32_fixp_unpack: arithmetic reference model + in-order scoreboard checked every
// cycle at the falling edge, with directed literal checks around the window edges.
module tb_fp32_fixp_unpack;

  localparam int EXP_LO    = 87;
  localparam int MAX_SHIFT = 104;
  localparam int CNT_MAX   = 65535;

  logic        clk;
  logic        rstn;
  logic [31:0] in_stream_tdata;
  logic        in_stream_tvalid;
  logic        in_stream_tready;
  logic [7:0]  in_acc_cs;
  logic [30:0] out_stream_tdata;
  logic        out_stream_tvalid;
  logic        out_stream_tready;
  logic [7:0]  out_acc_cs;
  logic        out_sign;
  logic        cnt_clr;
  logic [15:0] underflow_cnt;
  logic [15:0] overflow_cnt;
  logic [15:0] nan_inf_cnt;

  fp32_fixp_unpack #(.PRE_REG_WIDTH(128), .EXP_LO(87), .CNT_W(16)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .in_stream_tdata   (in_stream_tdata),
    .in_stream_tvalid  (in_stream_tvalid),
    .in_stream_tready  (in_stream_tready),
    .in_acc_cs         (in_acc_cs),
    .out_stream_tdata  (out_stream_tdata),
    .out_stream_tvalid (out_stream_tvalid),
    .out_stream_tready (out_stream_tready),
    .out_acc_cs        (out_acc_cs),
    .out_sign          (out_sign),
    .cnt_clr           (cnt_clr),
    .underflow_cnt     (underflow_cnt),
    .overflow_cnt      (overflow_cnt),
    .nan_inf_cnt       (nan_inf_cnt)
  );

  typedef struct packed {
    logic [30:0] td;
    logic        sign;
    logic [7:0]  cs;
  } exp_beat_t;

  exp_beat_t exp_q[$];
  int        n_cmp = 0;
  int        n_bad = 0;
  int        m_under = 0, m_over = 0, m_nan = 0;
  bit        rdy_mode = 0;
  bit        verbose = 1;
  bit        held = 0;
  logic [30:0] held_td;
  logic        held_sign;
  logic [7:0]  held_cs;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // kind: 0 pass-through/zero, 1 under, 2 over, 3 nan/inf
  function automatic void ref_decode(input logic [31:0] w, output logic [30:0] td, output int kind);
    int e, f, ex, m, s;
    e    = int'(w[30:23]);
    f    = int'(w[22:0]);
    td   = '0;
    kind = 0;
    if (e == 255) begin
      kind = 3;
    end else if (!(e == 0 && f == 0)) begin
      ex = (e == 0) ? 1 : e;
      m  = (e == 0) ? f : f + (1 << 23);
      s  = ex - EXP_LO;
      if (s < 0)              kind = 1;
      else if (s > MAX_SHIFT) kind = 2;
      else                    td = 31'(s * (1 << 24) + m);
    end
  endfunction

  // Compare process: scoreboard, counters and stall stability on every falling edge.
  always @(negedge clk) begin
    logic [30:0] td;
    int          kind;
    exp_beat_t   e;
    if (!rstn) begin
      exp_q.delete();
      m_under = 0; m_over = 0; m_nan = 0;
      held = 0;
      check("rst_out_tvalid", {31'd0, out_stream_tvalid}, 32'd0);
      check("rst_in_tready", {31'd0, in_stream_tready}, 32'd1);
      check("rst_out_tdata", {1'b0, out_stream_tdata}, 32'd0);
      check("rst_underflow_cnt", {16'd0, underflow_cnt}, 32'd0);
    end else begin
      check("underflow_cnt", {16'd0, underflow_cnt}, m_under);
      check("overflow_cnt", {16'd0, overflow_cnt}, m_over);
      check("nan_inf_cnt", {16'd0, nan_inf_cnt}, m_nan);
      if (held) begin
        check("stall_tvalid", {31'd0, out_stream_tvalid}, 32'd1);
        check("stall_tdata", {1'b0, out_stream_tdata}, {1'b0, held_td});
        check("stall_sign", {31'd0, out_sign}, {31'd0, held_sign});
        check("stall_cs", {24'd0, out_acc_cs}, {24'd0, held_cs});
      end
      if (out_stream_tvalid && out_stream_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {1'b0, out_stream_tdata}, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          check("out_tdata", {1'b0, out_stream_tdata}, {1'b0, e.td});
          check("out_sign", {31'd0, out_sign}, {31'd0, e.sign});
          check("out_acc_cs", {24'd0, out_acc_cs}, {24'd0, e.cs});
          if (verbose)
            $display("beat tdata=0x%08h sign=%0d cs=%0d exp_tdata=0x%08h",
                     out_stream_tdata, out_sign, out_acc_cs, e.td);
        end
      end
      held      = out_stream_tvalid && !out_stream_tready;
      held_td   = out_stream_tdata;
      held_sign = out_sign;
      held_cs   = out_acc_cs;
      if (in_stream_tvalid && in_stream_tready) begin
        ref_decode(in_stream_tdata, td, kind);
        exp_q.push_back('{td: td, sign: in_stream_tdata[31], cs: in_acc_cs});
        if (kind == 1 && m_under < CNT_MAX) m_under++;
        if (kind == 2 && m_over < CNT_MAX)  m_over++;
        if (kind == 3 && m_nan < CNT_MAX)   m_nan++;
      end
      if (cnt_clr) begin
        m_under = 0; m_over = 0; m_nan = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_stream_tready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [31:0] w, input logic [7:0] cs);
    int n;
    in_stream_tdata  = w;
    in_acc_cs        = cs;
    in_stream_tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_stream_tready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("in_tready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_stream_tvalid = 1'b0;
  endtask

  // Empty pipeline, out ready held high: checks the two-cycle latency and the beat itself.
  task automatic send_check(input logic [31:0] w, input logic [7:0] cs,
                            input logic [30:0] req_td, input logic req_sign, input string name);
    send(w, cs);
    check({name, "_early_tvalid"}, {31'd0, out_stream_tvalid}, 32'd0);
    @(posedge clk);
    #1;
    check({name, "_tvalid"}, {31'd0, out_stream_tvalid}, 32'd1);
    check({name, "_tdata"}, {1'b0, out_stream_tdata}, {1'b0, req_td});
    check({name, "_sign"}, {31'd0, out_sign}, {31'd0, req_sign});
    check({name, "_cs"}, {24'd0, out_acc_cs}, {24'd0, cs});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 2000) check("drain_timeout", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [7:0] e;
    case ($urandom_range(0, 5))
      0:       e = 8'd0;
      1:       e = 8'd255;
      2:       e = 8'($urandom_range(60, 86));
      3:       e = 8'($urandom_range(87, 191));
      4:       e = 8'($urandom_range(192, 254));
      default: e = 8'($urandom_range(0, 255));
    endcase
    return {1'($urandom_range(0, 1)), e, 23'($urandom())};
  endfunction

  initial begin
    logic [30:0] td;
    int          kind;
    rstn              = 1'b0;
    in_stream_tdata   = '0;
    in_stream_tvalid  = 1'b0;
    in_acc_cs         = '0;
    out_stream_tready = 1'b1;
    cnt_clr           = 1'b0;

    // Model pinned against hand-computed values.
    ref_decode(32'h3F80_0000, td, kind);
    check("model_one", {1'b0, td}, 32'h2880_0000);
    ref_decode(32'h5F80_0000, td, kind);
    check("model_2p64", {1'b0, td}, 32'h6880_0000);
    ref_decode(32'h6000_0000, td, kind);
    check("model_2p65_kind", kind, 32'd2);
    ref_decode(32'h7FC0_0000, td, kind);
    check("model_nan_kind", kind, 32'd3);

    #1;
    check("reset_tvalid", {31'd0, out_stream_tvalid}, 32'd0);
    check("reset_tready", {31'd0, in_stream_tready}, 32'd1);
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;

    send_check(32'h3F80_0000, 8'd5, {7'd40, 24'h80_0000}, 1'b0, "one");
    send_check(32'hAB80_0000, 8'd9, {7'd0, 24'h80_0000}, 1'b1, "m2pm40");
    send_check(32'h2B00_0000, 8'd1, 31'd0, 1'b0, "2pm41");
    check("under_after_2pm41", {16'd0, underflow_cnt}, 32'd1);
    send_check(32'h5F80_0000, 8'd2, {7'd104, 24'h80_0000}, 1'b0, "2p64");
    send_check(32'h6000_0000, 8'd3, 31'd0, 1'b0, "2p65");
    check("over_after_2p65", {16'd0, overflow_cnt}, 32'd1);
    send_check(32'h7FC0_0000, 8'd4, 31'd0, 1'b0, "nan");
    check("nan_after_nan", {16'd0, nan_inf_cnt}, 32'd1);
    send_check(32'h8000_0000, 8'd6, 31'd0, 1'b1, "neg_zero");
    check("under_after_zero", {16'd0, underflow_cnt}, 32'd1);

    rdy_mode = 1;
    for (int i = 0; i < 64; i++) begin
      send(rand_word(), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    rdy_mode = 0;
    drain();

    verbose = 0;
    for (int i = 0; i < CNT_MAX + 4; i++) send(32'h2B00_0000, 8'd0);
    check("under_saturated", {16'd0, underflow_cnt}, 32'h0000_FFFF);
    send(32'h2B00_0000, 8'd0);
    check("under_stays_sat", {16'd0, underflow_cnt}, 32'h0000_FFFF);
    cnt_clr = 1'b1;
    send(32'h2B00_0000, 8'd0);
    cnt_clr = 1'b0;
    check("clr_beats_inc", {16'd0, underflow_cnt}, 32'd0);
    drain();
    verbose = 1;

    send(32'h3F80_0000, 8'd11);
    send(32'h4000_0000, 8'd12);
    #1 rstn = 1'b0;
    #1;
    check("async_rst_tvalid", {31'd0, out_stream_tvalid}, 32'd0);
    check("async_rst_tdata", {1'b0, out_stream_tdata}, 32'd0);
    @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;
    check("no_stale_tvalid", {31'd0, out_stream_tvalid}, 32'd0);
    send_check(32'h4040_0000, 8'd7, {7'd41, 24'hC0_0000}, 1'b0, "post_rst");
    drain();
    check("queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
